// File: rtl/iterative_alu.sv
// Execute-stage ALU: single-cycle logic/arith/compare ops,
// serial one-bit-per-cycle shifts, valid/ready on both sides.
module iterative_alu #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DATA_WIDTH-1:0]  r_work;
  logic [SHAMT_WIDTH-1:0] r_cnt;
  logic [1:0]             r_kind;
  logic [DATA_WIDTH-1:0]  r_result;
  logic                   r_zero;

  logic                   w_accept;
  logic                   w_is_shift;
  logic                   w_last;
  logic                   w_lt;
  logic [SHAMT_WIDTH-1:0] w_shamt;
  logic [DATA_WIDTH-1:0]  w_sum;
  logic [DATA_WIDTH-1:0]  w_diff;
  logic [DATA_WIDTH-1:0]  w_alu;
  logic [DATA_WIDTH-1:0]  w_shifted;

  assign w_shamt    = src_b[SHAMT_WIDTH-1:0];
  assign w_accept   = in_valid && in_ready;
  assign w_is_shift = (Operation == 4'b0100) ||
                      (Operation == 4'b0101) ||
                      (Operation == 4'b0111);
  assign w_last     = (r_cnt == SHAMT_WIDTH'(1));
  assign w_sum      = src_a + src_b;
  assign w_diff     = src_a - src_b;
  assign w_lt       = $signed(src_a) < $signed(src_b);

  always_comb begin
    w_alu = '0;
    unique case (Operation)
      4'b0000: w_alu = src_a & src_b;
      4'b0001: w_alu = src_a | src_b;
      4'b0010: w_alu = w_sum;
      4'b0011: w_alu = w_diff;
      4'b0110: w_alu = src_a ^ src_b;
      4'b1000: w_alu = DATA_WIDTH'(src_a == src_b);
      4'b1001: w_alu = DATA_WIDTH'(src_a != src_b);
      4'b1011: w_alu = DATA_WIDTH'(w_lt);
      4'b1100: w_alu = DATA_WIDTH'(w_lt);
      4'b1101: w_alu = DATA_WIDTH'(!w_lt);
      4'b1111: w_alu = {w_sum[DATA_WIDTH-1:1], 1'b0};
      default: w_alu = '0;
    endcase
  end

  // r_kind holds Operation[1:0]: 00 SLL, 01 SRL, 11 SRA
  always_comb begin
    w_shifted = '0;
    unique case (r_kind)
      2'b00:   w_shifted = {r_work[DATA_WIDTH-2:0], 1'b0};
      2'b01:   w_shifted = {1'b0, r_work[DATA_WIDTH-1:1]};
      default: w_shifted = {r_work[DATA_WIDTH-1],
                            r_work[DATA_WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept)
          w_next = (w_is_shift && (w_shamt != '0))
                   ? S_SHIFT : S_DONE;
      end
      S_SHIFT: if (w_last) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE) && !reset;
    out_valid = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_work   <= '0;
      r_cnt    <= '0;
      r_kind   <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else if (w_accept) begin
      r_kind <= Operation[1:0];
      if (!w_is_shift) begin
        r_result <= w_alu;
        r_zero   <= (w_alu == '0);
      end else if (w_shamt == '0) begin
        r_result <= src_a;
        r_zero   <= (src_a == '0);
      end else begin
        r_work <= src_a;
        r_cnt  <= w_shamt;
      end
    end else if (r_state == S_SHIFT) begin
      r_work <= w_shifted;
      r_cnt  <= r_cnt - SHAMT_WIDTH'(1);
      if (w_last) begin
        r_result <= w_shifted;
        r_zero   <= (w_shifted == '0);
      end
    end
  end

  assign result = r_result;
  assign zero   = r_zero;

endmodule

// File: tb/tb_iterative_alu.sv
// Bench for iterative_alu: directed plan cases plus random
// ops checked against an arithmetic reference model.
module tb_iterative_alu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  Operation = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;

  int n_checks = 0;
  int n_fail = 0;

  iterative_alu #(
    .DATA_WIDTH(32),
    .SHAMT_WIDTH(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .Operation(Operation),
    .src_a(src_a),
    .src_b(src_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .zero(zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(
    input logic [3:0] op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a - b;
      4'd6:  return a ^ b;
      4'd4:  return a << sh;
      4'd5:  return a >> sh;
      4'd7:  return 32'($signed(a) >>> sh);
      4'd8:  return (a == b) ? 32'd1 : 32'd0;
      4'd9:  return (a != b) ? 32'd1 : 32'd0;
      4'd11: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd12: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd13: return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      4'd15: return (a + b) & 32'hFFFF_FFFE;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_lat(
    input logic [3:0] op,
    input logic [31:0] b
  );
    if ((op == 4'd4 || op == 4'd5 || op == 4'd7) && b[4:0] != 0)
      return int'(b[4:0]) + 1;
    return 1;
  endfunction

  // Issue one request, wait for the result, check it. If hold is
  // set, the result is left pending (out_ready stays low).
  task automatic do_op(
    input logic [3:0] op,
    input logic [31:0] a,
    input logic [31:0] b,
    input string nm,
    input bit hold
  );
    logic [31:0] exp_r;
    int lat;
    int want;
    exp_r = model(op, a, b);
    want = exp_lat(op, b);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle: in_ready=%b out_valid=%b want 1/0",
               nm, in_ready, out_valid);
    end
    in_valid = 1'b1;
    Operation = op;
    src_a = a;
    src_b = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    Operation = $urandom();
    src_a = $urandom();
    src_b = $urandom();
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (in_ready !== 1'b0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s busy_ready: in_ready=%b at cycle %0d want 0",
                 nm, in_ready, lat);
      end
    end while (!out_valid && lat < 64);
    n_checks++;
    if (lat != want || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", nm, lat, want);
    end
    n_checks++;
    if (result !== exp_r || zero !== (exp_r == 0)) begin
      n_fail++;
      $display("FAIL %s result: got %h z=%b want %h z=%b",
               nm, result, zero, exp_r, exp_r == 0);
    end
    if (!hold) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 ||
        result !== 32'd0 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: rdy=%b vld=%b res=%h z=%b want 0/0/0/0",
               in_ready, out_valid, result, zero);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: rdy=%b vld=%b want 1/0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_directed;
    do_op(4'b0010, 32'd5, 32'd7, "add", 0);
    do_op(4'b0011, 32'd3, 32'd5, "sub_neg", 0);
    do_op(4'b0011, 32'd9, 32'd9, "sub_zero", 0);
    do_op(4'b0111, 32'h8000_0000, 32'd4, "sra4", 0);
    do_op(4'b0101, 32'h8000_0000, 32'd4, "srl4", 0);
    do_op(4'b0100, 32'd1, 32'd31, "sll31", 0);
    do_op(4'b0100, 32'h1234, 32'h20, "sll0", 0);
    do_op(4'b1011, 32'hFFFF_FFFF, 32'd1, "lt", 0);
    do_op(4'b1101, 32'hFFFF_FFFF, 32'd1, "ge", 0);
    do_op(4'b1001, 32'd7, 32'd7, "ne", 0);
    do_op(4'b1111, 32'h1001, 32'h2, "jalr", 0);
    do_op(4'b1010, 32'hFFFF, 32'h1, "undef_a", 0);
    do_op(4'b1110, 32'hFFFF, 32'h1, "undef_e", 0);
  endtask

  task automatic test_backpressure;
    do_op(4'b0010, 32'd100, 32'd23, "bp_add", 1);
    in_valid = 1'b1;
    Operation = 4'b0000;
    src_a = 32'd0;
    src_b = 32'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          result !== 32'd123 || zero !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: vld=%b rdy=%b res=%h want 1/0/7b",
                 i, out_valid, in_ready, result);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        result !== 32'd123) begin
      n_fail++;
      $display("FAIL bp_release: vld=%b rdy=%b res=%h want 0/1/7b",
               out_valid, in_ready, result);
    end
    do_op(4'b0110, 32'hF0F0, 32'h0FF0, "bp_next", 0);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++)
      do_op(4'b0001, $urandom(), $urandom(), "b2b_or", 0);
  endtask

  task automatic test_random;
    logic [3:0] op;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      do_op(op, $urandom(), $urandom(), "rand", 0);
    end
  endtask

  task automatic test_reset_midop;
    @(negedge clk);
    in_valid = 1'b1;
    Operation = 4'b0100;
    src_a = 32'h0000_0ABC;
    src_b = 32'd20;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) begin
        n_checks++;
        n_fail++;
        $display("FAIL midop_early: out_valid=1 at cycle %0d", c);
      end
    end
    reset = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 2) reset = 1'b0;
      if (c == 3) begin
        n_checks++;
        if (result !== 32'd0 || out_valid !== 1'b0 ||
            in_ready !== 1'b1 || zero !== 1'b0) begin
          n_fail++;
          $display("FAIL midop_after: res=%h vld=%b rdy=%b want 0/0/1",
                   result, out_valid, in_ready);
        end
      end
      if (out_valid !== 1'b0) begin
        n_checks++;
        n_fail++;
        $display("FAIL midop_pulse: out_valid=1 at %0d", c);
      end
    end
    do_op(4'b0010, 32'd40, 32'd2, "midop_add", 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iterative_alu.md
Name: iterative_alu

Overview:
- Consumes the 4-bit ALU operation code produced by the ALU controller, together with two operands.
- Returns a registered result over a valid/ready handshake.
- Shifts run serially at one bit per cycle. Every other operation completes in one cycle.
- Sits in the multi-cycle execute stage, between the operand registers and the writeback/branch logic.

Parameters:
- DATA_WIDTH, 32, operand and result width.
- SHAMT_WIDTH, 5, shift-amount width; must equal log2(DATA_WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- Operation  input  4  ALU operation code (table below).
- src_a  input  DATA_WIDTH  operand A.
- src_b  input  DATA_WIDTH  operand B; shift amount is src_b[SHAMT_WIDTH-1:0].
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- result  output  DATA_WIDTH  registered result.
- zero  output  1  registered (result == 0).

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Operation codes:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 SUB (A-B); 0110 XOR.
  - 0100 SLL; 0101 SRL; 0111 SRA.
  - 1000 EQ, result = (A==B). 1001 NE, result = (A!=B).
  - 1011 LT signed, result = (A<B). 1100 SLT signed, same function as 1011. 1101 GE signed, result = (A>=B).
  - 1111 JALR target, result = (A+B) with bit0 forced to 0.
  - 1010 and 1110 are undefined; result = 0.
- Compare results are zero-extended to DATA_WIDTH. Add/sub wrap modulo 2^DATA_WIDTH; no overflow flag.
- FSM states: IDLE, SHIFT, DONE.
  - in_ready = (state==IDLE) && !reset.
  - out_valid = (state==DONE).
- Accept occurs when in_valid && in_ready. On accept, Operation, src_a and shamt are captured; later changes to the inputs are ignored.
- IDLE transitions:
  - Non-shift op: result and zero are written on the accept edge; next state DONE. out_valid rises the cycle after accept (latency 1).
  - Shift op with shamt==0: result = src_a; next state DONE (latency 1).
  - Shift op with shamt>0: working reg = src_a, count = shamt; next state SHIFT.
- SHIFT:
  - Each cycle: working reg shifted by 1 (SLL inserts 0 at LSB; SRL inserts 0 at MSB; SRA replicates MSB); count decrements.
  - When the count reaches 0 after that cycle's shift, result/zero are loaded and the next state is DONE.
  - Latency from accept to out_valid = shamt+1 cycles (max DATA_WIDTH cycles, i.e. shamt = DATA_WIDTH-1 gives latency DATA_WIDTH).
- DONE:
  - result/zero are held stable while out_valid && !out_ready.
  - On out_ready, next state IDLE; out_valid is low the following cycle.
  - No new request is accepted in DONE (in_ready=0); minimum issue interval is 2 cycles.
- in_valid asserted outside IDLE is ignored. The requester must hold it per standard valid/ready rules.
- Reset values, including reset asserted mid-operation: state IDLE, out_valid 0, result 0, zero 0, count 0, working reg 0. Any in-flight operation is discarded with no out_valid pulse. in_ready is 0 while reset is high and 1 the first cycle after release.
- Reset has priority over accept and completion in the same cycle.

Test Plan:
- ADD: src_a=5, src_b=7, Op=0010 accepted at cycle T -> out_valid at T+1, result=12, zero=0. SUB: 3-5 -> 0xFFFFFFFE. SUB: 9-9 -> result 0, zero=1.
- SRA: src_a=0x80000000, src_b=4, Op=0111 -> in_ready low for cycles T+1..T+4; out_valid at T+5; result=0xF8000000. Same operands with SRL (0101) -> 0x08000000. SLL: 1 by 31 -> 0x80000000 at T+32.
- Shift by 0: SLL src_a=0x1234, src_b=0x20 (shamt=0) -> latency 1, result 0x1234.
- Compares:
  - LT (1011): A=0xFFFFFFFF, B=1 -> 1.
  - GE (1101): same operands -> 0.
  - NE (1001): A=B=7 -> 0, zero=1.
  - JALR (1111): A=0x1001, B=0x2 -> 0x1002.
  - Undefined (1010) -> 0.
- Backpressure: complete an ADD, hold out_ready=0 for 3 cycles -> result stable, out_valid high, in_ready low, a new in_valid is not accepted. out_ready=1 -> IDLE; the next request is accepted one cycle later.
- Reset mid-op: start SLL by 20, assert reset at cycle T+6 -> no out_valid ever pulses for it; the cycle after release, result=0, out_valid=0, in_ready=1. A new ADD then completes normally.
